// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle for the register-hazard scoreboard.
// master drives the ID/WB side, slave is the scoreboard itself.
interface reg_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 3
);
    logic              issue_valid;
    logic              issue_ready;
    logic              issue_we;
    logic [AW-1:0]     issue_dest;
    logic [NRD-1:0]    src_need;
    logic [NRD*AW-1:0] src_addr;
    logic [NRD-1:0]    src_hit;
    logic              wb_valid;
    logic [AW-1:0]     wb_dest;
    logic              flush;
    logic [7:0]        inflight;
    logic [NREG-1:0]   busy_vec;
    logic              err;

    modport master (
        output issue_valid, issue_we, issue_dest, src_need, src_addr,
               wb_valid, wb_dest, flush,
        input  issue_ready, src_hit, inflight, busy_vec, err
    );

    modport slave (
        input  issue_valid, issue_we, issue_dest, src_need, src_addr,
               wb_valid, wb_dest, flush,
        output issue_ready, src_hit, inflight, busy_vec, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard sitting at ID. Keeps a pending-write counter per
// GPR (r0 never tracked), blocks issue on RAW hazards, on a saturated
// destination counter, or when the total of outstanding writes hits MAXF.
// Optional build macro SB_WB_BYPASS_EN: a WB write that retires the last
// pending write of a register unblocks readers of it in the same cycle
// (write-through regfile), saving one bubble.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 3,
    parameter int CW   = 2,
    parameter int MAXF = 6
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);
    localparam int             NSLOT   = 1 << AW;
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = '1;
    localparam logic [AW-1:0]  REG_ZERO = '0;

    // Slots at or above NREG exist only so any address indexes safely; they stay 0.
    logic [CW-1:0] cnt_r [NSLOT];
    logic [7:0]    total_r;
    logic          err_r;

    logic [AW-1:0]  src_a_s [NRD];
    logic [NRD-1:0] hit_s;
    logic           dest_full_s;
    logic           ready_s;
    logic           inc_s;
    logic           dec_s;
    logic           same_s;
    logic           uf_s;
    logic           inc_eff_s;
    logic           dec_eff_s;
    logic [NREG-1:0] busy_s;

    // Hazard detection, issue gating and update qualifiers from current state.
    always_comb begin
        dec_s = sb.wb_valid && (sb.wb_dest != REG_ZERO);
        hit_s = '0;
        for (int i = 0; i < NRD; i++) begin
            src_a_s[i] = sb.src_addr[i*AW +: AW];
            if (sb.src_need[i] && (src_a_s[i] != REG_ZERO) && (cnt_r[src_a_s[i]] != '0)) begin
`ifdef SB_WB_BYPASS_EN
                hit_s[i] = !(dec_s && (sb.wb_dest == src_a_s[i]) && (cnt_r[src_a_s[i]] == CNT_ONE));
`else
                hit_s[i] = 1'b1;
`endif
            end else begin
                hit_s[i] = 1'b0;
            end
        end

        if (sb.issue_we && (sb.issue_dest != REG_ZERO) && (cnt_r[sb.issue_dest] == CNT_MAX)) begin
`ifdef SB_WB_BYPASS_EN
            dest_full_s = !(dec_s && (sb.wb_dest == sb.issue_dest));
`else
            dest_full_s = 1'b1;
`endif
        end else begin
            dest_full_s = 1'b0;
        end

        ready_s   = !(|hit_s) && !dest_full_s && (total_r < 8'(MAXF));
        inc_s     = sb.issue_valid && ready_s && sb.issue_we && (sb.issue_dest != REG_ZERO);
        same_s    = inc_s && dec_s && (sb.issue_dest == sb.wb_dest);
        uf_s      = dec_s && !same_s && (cnt_r[sb.wb_dest] == '0);
        inc_eff_s = inc_s && !same_s;
        dec_eff_s = dec_s && !same_s && !uf_s;
    end

    // Busy decode of the tracked registers.
    always_comb begin
        busy_s = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_s[r] = (cnt_r[r] != '0);
        end
    end

    // Pending counters, outstanding total and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NSLOT; r++) begin
                cnt_r[r] <= '0;
            end
            total_r <= 8'd0;
            err_r   <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 0; r < NSLOT; r++) begin
                cnt_r[r] <= '0;
            end
            total_r <= 8'd0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_eff_s && (sb.issue_dest == AW'(r))) begin
                    cnt_r[r] <= cnt_r[r] + CNT_ONE;
                end else if (dec_eff_s && (sb.wb_dest == AW'(r))) begin
                    cnt_r[r] <= cnt_r[r] - CNT_ONE;
                end
            end
            case ({inc_eff_s, dec_eff_s})
                2'b10:   total_r <= total_r + 8'd1;
                2'b01:   total_r <= total_r - 8'd1;
                default: total_r <= total_r;
            endcase
            if (uf_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign sb.src_hit     = hit_s;
    assign sb.issue_ready = ready_s;
    assign sb.inflight    = total_r;
    assign sb.busy_vec    = busy_s;
    assign sb.err         = err_r;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand-written
// corner sequences, and randomized traffic against a counter-array model.
module tb_reg_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int CW   = 2;
    localparam int MAXF = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREG(NREG), .AW(AW), .NRD(NRD)) sb_if ();

    reg_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .CW(CW), .MAXF(MAXF)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_m [NREG];
    bit err_m;

    typedef struct {
        logic       iv;
        logic       we;
        logic [4:0] dest;
        logic [2:0] need;
        logic [4:0] a0;
        logic       wbv;
        logic [4:0] wbd;
        logic       exp_rdy;
        logic [2:0] exp_hit;
        int         exp_infl;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_total();
        int s = 0;
        for (int r = 1; r < NREG; r++) s += cnt_m[r];
        return s;
    endfunction

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b = '0;
        for (int r = 1; r < NREG; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    function automatic logic [2:0] m_hit(input logic [2:0] need, input logic [14:0] addr,
                                         input logic wbv, input logic [4:0] wbd);
        logic [2:0] h = '0;
        for (int i = 0; i < NRD; i++) begin
            int a = int'(addr[i*AW +: AW]);
            h[i] = need[i] && (a != 0) && (cnt_m[a] > 0);
`ifdef SB_WB_BYPASS_EN
            if (wbv && (int'(wbd) == a) && (a != 0) && (cnt_m[a] == 1)) h[i] = 1'b0;
`endif
        end
        return h;
    endfunction

    function automatic logic m_ready(input logic [2:0] h, input logic we, input logic [4:0] dest,
                                     input logic wbv, input logic [4:0] wbd);
        bit full = we && (dest != 5'd0) && (cnt_m[dest] == (1 << CW) - 1);
`ifdef SB_WB_BYPASS_EN
        if (wbv && (wbd == dest)) full = 1'b0;
`endif
        return (h == 3'b000) && !full && (m_total() < MAXF);
    endfunction

    task automatic cycle(input logic iv, input logic we, input logic [4:0] dest,
                         input logic [2:0] need, input logic [14:0] addr,
                         input logic wbv, input logic [4:0] wbd,
                         input logic fl, input logic rst,
                         output logic rdy_o, output logic [2:0] hit_o);
        logic [2:0] eh;
        logic       er;
        bit         inc, dec;
        sb_if.issue_valid = iv;
        sb_if.issue_we    = we;
        sb_if.issue_dest  = dest;
        sb_if.src_need    = need;
        sb_if.src_addr    = addr;
        sb_if.wb_valid    = wbv;
        sb_if.wb_dest     = wbd;
        sb_if.flush       = fl;
        reset             = rst;
        #2;
        eh    = m_hit(need, addr, wbv, wbd);
        er    = m_ready(eh, we, dest, wbv, wbd);
        rdy_o = sb_if.issue_ready;
        hit_o = sb_if.src_hit;
        chk("src_hit", 64'(hit_o), 64'(eh));
        chk("issue_ready", 64'(rdy_o), 64'(er));
        if (rst || fl) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
            if (rst) err_m = 1'b0;
        end else begin
            inc = iv && er && we && (dest != 5'd0);
            dec = wbv && (wbd != 5'd0);
            if (!(inc && dec && dest == wbd)) begin
                if (inc) cnt_m[dest]++;
                if (dec) begin
                    if (cnt_m[wbd] == 0) err_m = 1'b1;
                    else cnt_m[wbd]--;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("inflight", 64'(sb_if.inflight), 64'(m_total()));
        chk("busy_vec", 64'(sb_if.busy_vec), 64'(m_busy()));
        chk("err", 64'(sb_if.err), 64'(err_m));
    endtask

    logic       rdy;
    logic [2:0] hit;

    task automatic do_reset();
        cycle(1'b0, 1'b0, 5'd0, 3'd0, 15'd0, 1'b0, 5'd0, 1'b0, 1'b1, rdy, hit);
    endtask

    task automatic issue(input logic [4:0] d);
        cycle(1'b1, 1'b1, d, 3'd0, 15'd0, 1'b0, 5'd0, 1'b0, 1'b0, rdy, hit);
    endtask

    task automatic wb(input logic [4:0] d);
        cycle(1'b0, 1'b0, 5'd0, 3'd0, 15'd0, 1'b1, d, 1'b0, 1'b0, rdy, hit);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        reset = 1'b1;
        sb_if.issue_valid = 1'b0; sb_if.issue_we = 1'b0; sb_if.issue_dest = 5'd0;
        sb_if.src_need = 3'd0; sb_if.src_addr = 15'd0; sb_if.wb_valid = 1'b0;
        sb_if.wb_dest = 5'd0; sb_if.flush = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_inflight", 64'(sb_if.inflight), 64'd0);
        chk("reset_busy", 64'(sb_if.busy_vec), 64'd0);
        chk("reset_err", 64'(sb_if.err), 64'd0);
        chk("reset_ready", 64'(sb_if.issue_ready), 64'd1);

        // iv we dest need a0 wbv wbd | ready hit inflight-after
        tbl.push_back('{1'b1, 1'b1, 5'd4, 3'b000, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b1, 1'b1, 5'd8, 3'b001, 5'd4, 1'b0, 5'd0, 1'b0, 3'b001, 1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b000, 5'd0, 1'b1, 5'd4, 1'b1, 3'b000, 0});
        tbl.push_back('{1'b1, 1'b1, 5'd8, 3'b001, 5'd4, 1'b0, 5'd0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b000, 5'd0, 1'b1, 5'd8, 1'b1, 3'b000, 0});
        tbl.push_back('{1'b1, 1'b1, 5'd7, 3'b000, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b1, 1'b1, 5'd7, 3'b000, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 2});
        tbl.push_back('{1'b1, 1'b1, 5'd7, 3'b000, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 3});
        tbl.push_back('{1'b1, 1'b1, 5'd7, 3'b000, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 3});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b001, 5'd7, 1'b1, 5'd7, 1'b0, 3'b001, 2});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b001, 5'd7, 1'b1, 5'd7, 1'b0, 3'b001, 1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b001, 5'd7, 1'b0, 5'd0, 1'b0, 3'b001, 1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b000, 5'd0, 1'b1, 5'd7, 1'b1, 3'b000, 0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b001, 5'd7, 1'b0, 5'd0, 1'b1, 3'b000, 0});
        tbl.push_back('{1'b1, 1'b1, 5'd9, 3'b000, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b1, 1'b1, 5'd9, 3'b000, 5'd0, 1'b1, 5'd9, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b1, 1'b1, 5'd5, 3'b000, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 2});
        tbl.push_back('{1'b1, 1'b1, 5'd3, 3'b000, 5'd0, 1'b1, 5'd5, 1'b1, 3'b000, 2});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b000, 5'd0, 1'b1, 5'd9, 1'b1, 3'b000, 1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b000, 5'd0, 1'b1, 5'd3, 1'b1, 3'b000, 0});
        tbl.push_back('{1'b1, 1'b1, 5'd0, 3'b001, 5'd0, 1'b0, 5'd0, 1'b1, 3'b000, 0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 3'b000, 5'd0, 1'b1, 5'd0, 1'b1, 3'b000, 0});

        foreach (tbl[k]) begin
            cycle(tbl[k].iv, tbl[k].we, tbl[k].dest, tbl[k].need, {10'd0, tbl[k].a0},
                  tbl[k].wbv, tbl[k].wbd, 1'b0, 1'b0, rdy, hit);
            chk($sformatf("tbl%0d_ready", k), 64'(rdy), 64'(tbl[k].exp_rdy));
            chk($sformatf("tbl%0d_hit", k), 64'(hit), 64'(tbl[k].exp_hit));
            chk($sformatf("tbl%0d_inflight", k), 64'(sb_if.inflight), 64'(tbl[k].exp_infl));
        end
        chk("tbl_err_clear", 64'(sb_if.err), 64'd0);

        // MAXF limit also applies to an instruction without a destination
        do_reset();
        for (int r = 1; r <= 6; r++) issue(5'(r));
        chk("maxf_inflight", 64'(sb_if.inflight), 64'd6);
        cycle(1'b1, 1'b0, 5'd0, 3'd0, 15'd0, 1'b0, 5'd0, 1'b0, 1'b0, rdy, hit);
        chk("maxf_block", 64'(rdy), 64'd0);
        cycle(1'b1, 1'b0, 5'd0, 3'd0, 15'd0, 1'b1, 5'd1, 1'b0, 1'b0, rdy, hit);
        chk("maxf_block_wbcycle", 64'(rdy), 64'd0);
        cycle(1'b1, 1'b0, 5'd0, 3'd0, 15'd0, 1'b0, 5'd0, 1'b0, 1'b0, rdy, hit);
        chk("maxf_release", 64'(rdy), 64'd1);
        chk("maxf_nodest_untracked", 64'(sb_if.inflight), 64'd5);

        // Underflow is sticky, survives flush, cleared only by reset
        do_reset();
        wb(5'd10);
        chk("uf_err", 64'(sb_if.err), 64'd1);
        chk("uf_inflight", 64'(sb_if.inflight), 64'd0);
        issue(5'd2); issue(5'd3); issue(5'd4);
        chk("uf_sticky", 64'(sb_if.err), 64'd1);
        chk("pre_flush_inflight", 64'(sb_if.inflight), 64'd3);
        cycle(1'b1, 1'b1, 5'd6, 3'd0, 15'd0, 1'b1, 5'd2, 1'b1, 1'b0, rdy, hit);
        chk("flush_inflight", 64'(sb_if.inflight), 64'd0);
        chk("flush_busy", 64'(sb_if.busy_vec), 64'd0);
        chk("flush_err_kept", 64'(sb_if.err), 64'd1);
        do_reset();
        chk("reset_clears_err", 64'(sb_if.err), 64'd0);

        // Same-cycle WB retiring the last write of a source register
        issue(5'd4);
        cycle(1'b1, 1'b0, 5'd0, 3'b001, 15'd4, 1'b1, 5'd4, 1'b0, 1'b0, rdy, hit);
`ifdef SB_WB_BYPASS_EN
        chk("wb_same_cycle_ready", 64'(rdy), 64'd1);
`else
        chk("wb_same_cycle_ready", 64'(rdy), 64'd0);
`endif
        cycle(1'b1, 1'b0, 5'd0, 3'b001, 15'd4, 1'b0, 5'd0, 1'b0, 1'b0, rdy, hit);
        chk("wb_next_cycle_ready", 64'(rdy), 64'd1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [14:0] a;
            a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  3'($urandom), a, 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0), rdy, hit);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the in-order 5-stage LoongArch pipeline.
- Replaces the fixed 3-stage dest-compare interlock with per-register pending-write counters.
- Sits at ID: gates instruction issue to EX, is decremented on WB register write, and is cleared on pipeline flush.
- Supports any pipeline depth and multiple outstanding writes to the same register.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is hardwired zero.
- AW, 5, register-address width; must satisfy 2^AW >= NREG.
- NRD, 3, number of source-operand read ports checked per issuing instruction.
- CW, 2, per-register pending-counter width; max pending writes per register = 2^CW-1.
- MAXF, 6, max total outstanding writes across all registers; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  ID holds a valid instruction wishing to advance to EX
- issue_ready  out  1  no hazard and capacity available; issue fires when issue_valid && issue_ready
- issue_we  in  1  issuing instruction writes a GPR
- issue_dest  in  AW  destination register of issuing instruction
- src_need  in  NRD  per-port operand-used flag
- src_addr  in  NRD*AW  per-port source register; port i occupies bits [i*AW +: AW]
- src_hit  out  NRD  per-port RAW hazard flag
- wb_valid  in  1  WB stage commits a GPR write this cycle
- wb_dest  in  AW  register written by WB
- flush  in  1  kill all in-flight instructions; clears scoreboard
- inflight  out  8  total outstanding writes
- busy_vec  out  NREG  bit r = counter[r] != 0
- err  out  1  sticky underflow/overflow error

Behaviour:
- State consists of:
  - cnt[r], CW bits, for r = 1..NREG-1; cnt[0] is constant 0.
  - total, 8 bits.
  - err, sticky.
- Reset: all cnt = 0, total = 0, err = 0, so busy_vec = 0 and inflight = 0. With no pending entries, src_hit = 0 and issue_ready = 1.
- src_hit[i] = src_need[i] && src_addr_i != 0 && cnt[src_addr_i] != 0. This is combinational from current state; no same-cycle issue-to-issue forwarding.
- dest_full = issue_we && issue_dest != 0 && cnt[issue_dest] == 2^CW-1.
- issue_ready = !(|src_hit) && !dest_full && (total < MAXF). This is combinational; issue_ready must not depend on issue_valid.
- inc = issue_valid && issue_ready && issue_we && issue_dest != 0.
- dec = wb_valid && wb_dest != 0.
- Counter update on posedge, priority order highest first:
  - reset.
  - flush: all cnt and total go to 0; err unchanged. Any inc or dec in the same cycle is ignored.
  - inc && dec on the same register: that cnt is unchanged; total is unchanged.
  - inc and dec on different registers: each counter moves independently (one +1, one -1); total is unchanged.
  - inc only: cnt +1, total +1.
  - dec only: cnt -1, total -1.
- Underflow: dec when cnt[wb_dest] == 0 and no same-register inc. The counter stays at 0, total is unchanged, and err is set.
- Overflow of total cannot occur, because issue is gated by total < MAXF.
- Destination r0, and wb_dest == 0: never tracked; never set err.
- Latency:
  - An issue with a tracked dest raises src_hit for a dependent instruction in the following cycle.
  - A WB decrement to 0 clears src_hit in the following cycle (base build).
- Instructions without a dest (stores, branches) still fire on issue_valid && issue_ready but do not touch the counters. The inflight MAXF limit applies to them too.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: WB to ID same-cycle write-through.
  - src_hit[i] is additionally masked when dec && wb_dest == src_addr_i && cnt[src_addr_i] == 1.
  - Same masking applies to dest_full when dec && wb_dest == issue_dest.
  - The regfile is write-through in this build, so the dependent issues in the WB cycle, saving one bubble.
- Undefined: no masking; hazards clear one cycle after the final WB, which matches the base latency above.

Test Plan:
- Reset, then issue add r4 (we=1, dest=4) -> next cycle busy_vec[4]=1 and inflight=1. A dependent with src_need[0]=1, src_addr0=4 sees src_hit=3'b001 and issue_ready=0. wb_valid with dest=4 -> busy_vec[4]=0 next cycle and the dependent issues.
- Two issues to r7 back-to-back, then a third -> cnt[7]=3 blocks the 4th via dest_full (CW=2). Two WBs to r7 -> cnt[7]=1, still hit; a third WB -> 0, clear.
- Same cycle: issue dest=9 and wb_dest=9 with cnt[9]=1 -> cnt[9] stays 1 and inflight is unchanged. Issue dest=3 with wb_dest=5 -> cnt[3]+1, cnt[5]-1.
- MAXF=6: issue 6 writers to r1..r6 -> issue_ready=0 for an independent 7th instruction; one WB -> ready=1.
- wb_valid dest=10 with cnt[10]=0 -> err=1 (sticky through further traffic), counters unchanged. Then flush with 3 pending -> inflight=0, busy_vec=0, err still 1. Then reset -> err=0.
- With SB_WB_BYPASS_EN defined: cnt[4]=1, wb_dest=4, and a dependent reading r4 in the same cycle -> issue_ready=1 in that cycle. Without the macro defined -> issue_ready=0 in that cycle and 1 the next.
- r0 dest and r0 source: never hit, never counted.
